mem_region_router: RTL and testbench
====================================

MEM_REGION_ROUTER -- requirements
Module: mem_region_router

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port im_bottom, input, 64: inclusive lower bound of the instruction-memory region.
REQ-004 SHALL have port im_top, input, 64: inclusive upper bound of the instruction-memory region.
REQ-005 SHALL have port dm_bottom, input, 64: inclusive lower bound of the data-memory region.
REQ-006 SHALL have port dm_top, input, 64: inclusive upper bound of the data-memory region.
REQ-007 SHALL have port continue_val, input, 1: run enable; low blocks new CPU requests.
REQ-008 SHALL have port req_valid, input, 1: CPU request valid.
REQ-009 SHALL have port req_ready, output, 1: router accepts the CPU request.
REQ-010 SHALL have port req_addr, input, 64: CPU byte address.
REQ-011 SHALL have port req_we, input, 1: 1 = write, 0 = read.
REQ-012 SHALL have port req_wdata, input, 64: write data.
REQ-013 SHALL have port rsp_valid, output, 1: one-cycle response pulse to the CPU, no backpressure.
REQ-014 SHALL have port rsp_rdata, output, 64: read data (0 on writes and faults).
REQ-015 SHALL have port rsp_err, output, 1: address is outside both regions.
REQ-016 SHALL have ports mem_addr, mem_we and mem_wdata, output, 64/1/64: latched request, shared by both memories.
REQ-017 SHALL have ports im_req_valid and dm_req_valid, output, 1: per-memory request valid.
REQ-018 SHALL have ports im_req_ready and dm_req_ready, input, 1: per-memory request accept.
REQ-019 SHALL have ports im_rsp_valid/im_rsp_rdata and dm_rsp_valid/dm_rsp_rdata, input, 1/64: per-memory completion and read data.
REQ-020 SHALL have port fault_count, output, 16: count of faulted requests.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-022 SHALL drive req_ready = (state==IDLE) && continue_val, combinationally.
REQ-023 SHALL, on the req_valid&&req_ready handshake in cycle N, latch addr/we/wdata and decode the region: IM if im_bottom<=addr<=im_top, else DM if dm_bottom<=addr<=dm_top, else NONE (unsigned, inclusive bounds).
REQ-024 SHALL give IM priority when the two regions overlap.
REQ-025 SHALL go to ISSUE for region IM/DM; for region NONE it SHALL go to RESP with rsp_err=1, so rsp_valid is seen in cycle N+1.
REQ-026 SHALL, in ISSUE, assert only the selected x_req_valid with stable mem_* until x_req_ready=1, then go to WAIT.
REQ-027 SHALL, in WAIT, on the selected x_rsp_valid, register rdata (reads) or 0 (writes) and go to RESP; best case rsp_valid is at N+3.
REQ-028 SHALL ignore rsp_valid from the non-selected memory, and memory responses in any state other than WAIT.
REQ-029 SHALL, in RESP, assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-030 SHALL freeze the region decision at accept; bound changes mid-transaction SHALL NOT affect it.
REQ-031 SHALL let an in-flight transaction complete normally when continue_val falls.

Reset
REQ-032 SHALL, under reset, go to IDLE and hold req_ready, im_req_valid, dm_req_valid, rsp_valid and rsp_err at 0, and rsp_rdata, mem_addr, mem_wdata, mem_we and fault_count at 0.
REQ-033 SHALL, on reset mid-transaction, drop the transaction with no response; memories SHALL see x_req_valid=0 from the next cycle.

Configuration
REQ-034 SHALL, with MEM_ROUTER_FAULT_CNT_EN defined, increment fault_count by 1 per NONE-region accept, saturating at 0xFFFF; without the macro, fault_count SHALL be tied to 0, with the port retained.

Structure
REQ-035 SHALL use shared package hermes_mem_pkg holding ADDR_W=64, DATA_W=64, region_e {REG_IM, REG_DM, REG_NONE}, the router state enum, and the default bounds IM 0x0-0x7_ffff_ffff and DM 0x8_0000_0000-0xf_ffff_ffff.
REQ-036 SHALL contain exactly one sub-module, region_decode: combinational address-to-region_e comparator.

Verification
REQ-037 SHALL verify: default bounds, read 0x0000_0010, im_req_ready=1 and im_rsp at the next cycle with 0xDEAD_BEEF -> rsp_valid at N+3, rdata 0xDEAD_BEEF, rsp_err 0, dm_req_valid never 1.
REQ-038 SHALL verify: write 0x8_0000_0000 with data 0x1234, dm_req_ready held low for 3 cycles -> dm_req_valid and mem_* stable throughout, rsp_valid once with rdata 0.
REQ-039 SHALL verify: read 0x10_0000_0000 -> no memory valid, rsp_valid and rsp_err at N+1, fault_count 1 (or 0 without the macro).
REQ-040 SHALL verify: continue_val=0 with req_valid=1 -> req_ready 0 and nothing issued; continue_val falling during WAIT -> the transaction completes.
REQ-041 SHALL verify: reset asserted in WAIT -> IDLE next cycle, all valids 0, and no rsp_valid after the late im_rsp_valid.
REQ-042 SHALL verify: boundary addresses 0x7_ffff_ffff -> IM, 0xf_ffff_ffff -> DM, and an overlapping-bounds address -> IM.

Source files
------------

// File: rtl/hermes_mem_pkg.sv
// Shared types and constants for the Hermes memory router: widths, region and
// router-state enums, default region bounds and a saturating counter helper.
package hermes_mem_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    REG_IM,
    REG_DM,
    REG_NONE
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } router_state_e;

  localparam logic [ADDR_W-1:0] IM_BOTTOM_DEF = 64'h0000_0000_0000_0000;
  localparam logic [ADDR_W-1:0] IM_TOP_DEF    = 64'h0000_0007_ffff_ffff;
  localparam logic [ADDR_W-1:0] DM_BOTTOM_DEF = 64'h0000_0008_0000_0000;
  localparam logic [ADDR_W-1:0] DM_TOP_DEF    = 64'h0000_000f_ffff_ffff;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_region_router_region_decode.sv
// Combinational address-to-region comparator; instruction memory wins when the
// two inclusive, unsigned ranges overlap.
module region_decode
  import hermes_mem_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] im_bottom_i,
  input  logic [ADDR_W-1:0] im_top_i,
  input  logic [ADDR_W-1:0] dm_bottom_i,
  input  logic [ADDR_W-1:0] dm_top_i,
  output region_e           region_o
);

  logic in_im;
  logic in_dm;

  assign in_im = (addr_i >= im_bottom_i) && (addr_i <= im_top_i);
  assign in_dm = (addr_i >= dm_bottom_i) && (addr_i <= dm_top_i);

  always_comb begin
    region_o = REG_NONE;
    if (in_im) begin
      region_o = REG_IM;
    end else if (in_dm) begin
      region_o = REG_DM;
    end
  end

endmodule

// File: rtl/mem_region_router.sv
// Routes single outstanding CPU requests to instruction or data memory by address
// region. Optional fault counter enabled by defining MEM_ROUTER_FAULT_CNT_EN.
module mem_region_router
  import hermes_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] im_bottom,
  input  logic [ADDR_W-1:0] im_top,
  input  logic [ADDR_W-1:0] dm_bottom,
  input  logic [ADDR_W-1:0] dm_top,
  input  logic              continue_val,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              im_req_valid,
  output logic              dm_req_valid,
  input  logic              im_req_ready,
  input  logic              dm_req_ready,
  input  logic              im_rsp_valid,
  input  logic [DATA_W-1:0] im_rsp_rdata,
  input  logic              dm_rsp_valid,
  input  logic [DATA_W-1:0] dm_rsp_rdata,
  output logic [15:0]       fault_count
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid, once raised, holds with stable payload until that edge.
  router_state_e     state_q;
  region_e           region_q;
  region_e           region_d;
  logic              im_req_valid_q;
  logic              dm_req_valid_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              accept;
  logic              sel_req_ready;
  logic              sel_rsp_valid;
  logic [DATA_W-1:0] sel_rsp_rdata;

  region_decode u_region_decode (
    .addr_i      (req_addr),
    .im_bottom_i (im_bottom),
    .im_top_i    (im_top),
    .dm_bottom_i (dm_bottom),
    .dm_top_i    (dm_top),
    .region_o    (region_d)
  );

  assign req_ready = !reset && (state_q == ST_IDLE) && continue_val;
  assign accept    = req_valid && req_ready;

  // Only the memory chosen at accept time may advance the transaction.
  always_comb begin
    sel_req_ready = 1'b0;
    sel_rsp_valid = 1'b0;
    sel_rsp_rdata = '0;
    case (region_q)
      REG_IM: begin
        sel_req_ready = im_req_ready;
        sel_rsp_valid = im_rsp_valid;
        sel_rsp_rdata = im_rsp_rdata;
      end
      REG_DM: begin
        sel_req_ready = dm_req_ready;
        sel_rsp_valid = dm_rsp_valid;
        sel_rsp_rdata = dm_rsp_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      region_q       <= REG_NONE;
      im_req_valid_q <= 1'b0;
      dm_req_valid_q <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_rdata_q    <= '0;
      mem_addr_q     <= '0;
      mem_we_q       <= 1'b0;
      mem_wdata_q    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            mem_addr_q  <= req_addr;
            mem_we_q    <= req_we;
            mem_wdata_q <= req_wdata;
            region_q    <= region_d;
            if (region_d == REG_NONE) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= ST_RESP;
            end else begin
              im_req_valid_q <= (region_d == REG_IM);
              dm_req_valid_q <= (region_d == REG_DM);
              state_q        <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (sel_req_ready) begin
            im_req_valid_q <= 1'b0;
            dm_req_valid_q <= 1'b0;
            state_q        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sel_rsp_valid) begin
            rsp_rdata_q <= mem_we_q ? '0 : sel_rsp_rdata;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_err_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign im_req_valid = im_req_valid_q;
  assign dm_req_valid = dm_req_valid_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign mem_addr     = mem_addr_q;
  assign mem_we       = mem_we_q;
  assign mem_wdata    = mem_wdata_q;

`ifdef MEM_ROUTER_FAULT_CNT_EN
  logic [15:0] fault_q;
  logic [15:0] fault_d;

  assign fault_d = sat_inc16(fault_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= '0;
    end else if (accept && (region_d == REG_NONE)) begin
      fault_q <= fault_d;
    end
  end

  assign fault_count = fault_q;
`else
  assign fault_count = '0;
`endif

endmodule

// File: tb/tb_mem_region_router.sv
// Scoreboard bench for mem_region_router: directed scenarios plus randomized
// traffic against a region/latency reference model and two memory responders.
module tb_mem_region_router;
  import hermes_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] im_bottom, im_top, dm_bottom, dm_top;
  logic        continue_val, req_valid, req_ready, req_we;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic        im_req_valid, dm_req_valid;
  logic        m_req_valid [2];
  logic        m_req_ready [2];
  logic        m_rsp_valid [2];
  logic [63:0] m_rsp_rdata [2];
  logic [15:0] fault_count;

  always #5 clk = ~clk;

  assign m_req_valid[0] = im_req_valid;
  assign m_req_valid[1] = dm_req_valid;

  mem_region_router dut (
    .clk          (clk),
    .reset        (reset),
    .im_bottom    (im_bottom),
    .im_top       (im_top),
    .dm_bottom    (dm_bottom),
    .dm_top       (dm_top),
    .continue_val (continue_val),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_we       (req_we),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .im_req_valid (im_req_valid),
    .dm_req_valid (dm_req_valid),
    .im_req_ready (m_req_ready[0]),
    .dm_req_ready (m_req_ready[1]),
    .im_rsp_valid (m_rsp_valid[0]),
    .im_rsp_rdata (m_rsp_rdata[0]),
    .dm_rsp_valid (m_rsp_valid[1]),
    .dm_rsp_rdata (m_rsp_rdata[1]),
    .fault_count  (fault_count)
  );

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
    logic [31:0] lat;
    logic [31:0] acc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rdy_dly [2];
  int          rsp_dly [2];
  bit          noise_en = 1'b0;
  bit          ovr_en = 1'b0;
  logic [63:0] ovr_data = '0;
  logic [63:0] cur_addr = '0;
  logic [63:0] cur_wdata = '0;
  logic        cur_we = 1'b0;
  int          cur_region = 2;
  int          fault_exp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: 0 = IM, 1 = DM, 2 = no region; IM checked first.
  function automatic int model_region(input logic [63:0] a);
    if (a >= im_bottom && a <= im_top) return 0;
    if (a >= dm_bottom && a <= dm_top) return 1;
    return 2;
  endfunction

  function automatic logic [63:0] mem_data(input int m, input logic [63:0] a);
    if (ovr_en) return ovr_data;
    return a ^ ((m == 0) ? 64'hA5A5_5A5A_0000_1111 : 64'h3C3C_C3C3_2222_0000);
  endfunction

  task automatic set_bounds(input logic [63:0] ib, input logic [63:0] it,
                            input logic [63:0] db, input logic [63:0] dt);
    im_bottom = ib; im_top = it; dm_bottom = db; dm_top = dt;
  endtask

  // Memory responder: holds ready low rdy_dly cycles, answers rsp_dly cycles
  // after accept, and optionally injects stray responses while not selected.
  task automatic mem_resp(input int m);
    int          wait_n = 0;
    int          rsp_cnt = -1;
    logic [63:0] data_hold = '0;
    m_req_ready[m] = 1'b0;
    m_rsp_valid[m] = 1'b0;
    m_rsp_rdata[m] = '0;
    forever begin
      @(negedge clk);
      m_req_ready[m] = 1'b0;
      m_rsp_valid[m] = 1'b0;
      m_rsp_rdata[m] = {$urandom, $urandom};
      if (rsp_cnt == 0) begin
        m_rsp_valid[m] = 1'b1;
        m_rsp_rdata[m] = data_hold;
        rsp_cnt = -1;
      end else if (rsp_cnt > 0) begin
        rsp_cnt--;
      end
      if (m_req_valid[m]) begin
        chk((m == 0) ? "im_mem_addr" : "dm_mem_addr", mem_addr, cur_addr);
        chk((m == 0) ? "im_mem_we" : "dm_mem_we", {63'd0, mem_we}, {63'd0, cur_we});
        chk((m == 0) ? "im_mem_wdata" : "dm_mem_wdata", mem_wdata, cur_wdata);
        if (wait_n >= rdy_dly[m]) begin
          m_req_ready[m] = 1'b1;
          data_hold = mem_data(m, cur_addr);
          rsp_cnt = rsp_dly[m];
          wait_n = 0;
        end else begin
          wait_n++;
        end
      end else if (noise_en && rsp_cnt < 0 && !m_rsp_valid[m] && $urandom_range(0, 3) == 0) begin
        m_rsp_valid[m] = 1'b1;
      end
    end
  endtask

  initial begin
    fork
      mem_resp(0);
      mem_resp(1);
    join_none
  end

  // Monitor: routing of request valids and every response pulse.
  initial begin
    bit   prev_rsp = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (m_req_valid[m]) chk("req_valid_route", m, cur_region);
      end
      if (rsp_valid) begin
        chk("rsp_single_cycle", {63'd0, prev_rsp}, 64'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=0x%0h err=%0d expected no response (cycle %0d)",
                   rsp_rdata, rsp_err, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
          if (e.lat != 0) chk("rsp_latency", cyc - int'(e.acc), {32'd0, e.lat});
        end
      end
      prev_rsp = rsp_valid;
    end
  end

  task automatic send(input logic [63:0] a, input logic we_, input logic [63:0] wd, input bit push);
    int   r;
    int   n = 0;
    exp_t e;
    r = model_region(a);
    cur_addr = a; cur_we = we_; cur_wdata = wd; cur_region = r;
    req_addr = a; req_we = we_; req_wdata = wd; req_valid = 1'b1;
    #1;
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      cur_region = 2;
      return;
    end
    e.rdata = (r == 2 || we_) ? 64'd0 : mem_data(r, a);
    e.err   = (r == 2);
    e.lat   = (r == 2) ? 32'd1 : 32'(3 + rdy_dly[r] + rsp_dly[r]);
    e.acc   = 32'(cyc);
    if (push) exp_q.push_back(e);
`ifdef MEM_ROUTER_FAULT_CNT_EN
    if (r == 2 && fault_exp < 16'hFFFF) fault_exp++;
`endif
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_we    = 1'($urandom_range(0, 1));
    req_wdata = {$urandom, $urandom};
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout: got no response after %0d cycles expected 1 response", n);
      exp_q.delete();
    end
    @(negedge clk);
    cur_region = 2;
    chk("fault_count", {48'd0, fault_count}, 64'(fault_exp));
  endtask

  task automatic txn(input logic [63:0] a, input logic we_, input logic [63:0] wd);
    send(a, we_, wd, 1'b1);
    wait_done();
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL global_timeout: got no completion expected finish before 1ms");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    reset = 1'b1; continue_val = 1'b1; req_valid = 1'b0;
    req_addr = '0; req_we = 1'b0; req_wdata = '0;
    set_bounds(IM_BOTTOM_DEF, IM_TOP_DEF, DM_BOTTOM_DEF, DM_TOP_DEF);
    for (int m = 0; m < 2; m++) begin rdy_dly[m] = 0; rsp_dly[m] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_im_req_valid", {63'd0, im_req_valid}, 64'd0);
    chk("rst_dm_req_valid", {63'd0, dm_req_valid}, 64'd0);
    chk("rst_fault_count", {48'd0, fault_count}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Best-case IM read returning a fixed word.
    ovr_en = 1'b1; ovr_data = 64'h0000_0000_DEAD_BEEF;
    txn(64'h0000_0010, 1'b0, 64'd0);
    ovr_en = 1'b0;

    // DM write with ready held low for three cycles.
    rdy_dly[1] = 3;
    txn(64'h8_0000_0000, 1'b1, 64'h1234);
    rdy_dly[1] = 0;

    // Address outside both regions: immediate error response.
    txn(64'h10_0000_0000, 1'b0, 64'd0);

    // Run enable low blocks acceptance entirely.
    continue_val = 1'b0;
    req_valid = 1'b1; req_addr = 64'h20; req_we = 1'b0; req_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("blocked_req_ready", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    continue_val = 1'b1;
    @(negedge clk);

    // Run enable falling during WAIT lets the transaction finish.
    rsp_dly[0] = 4;
    send(64'h400, 1'b0, 64'd0, 1'b1);
    @(negedge clk);
    continue_val = 1'b0;
    wait_done();
    continue_val = 1'b1;

    // Bounds rewritten mid-transaction do not change the frozen region.
    rsp_dly[0] = 2;
    send(64'h40, 1'b0, 64'd0, 1'b1);
    set_bounds(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    wait_done();
    set_bounds(IM_BOTTOM_DEF, IM_TOP_DEF, DM_BOTTOM_DEF, DM_TOP_DEF);

    // Reset while waiting on the IM response: dropped, late response ignored.
    rsp_dly[0] = 3;
    send(64'h100, 1'b0, 64'd0, 1'b0);
    @(negedge clk);
    chk("wait_state", 64'(dut.state_q), 64'(ST_WAIT));
    reset = 1'b1;
    @(negedge clk);
    chk("rst_wait_state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("rst_wait_im_valid", {63'd0, im_req_valid}, 64'd0);
    chk("rst_wait_dm_valid", {63'd0, dm_req_valid}, 64'd0);
    chk("rst_wait_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_wait_req_ready", {63'd0, req_ready}, 64'd0);
    reset = 1'b0;
    fault_exp = 0;
    cur_region = 2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_rsp_after_reset", {63'd0, rsp_valid}, 64'd0);
    end
    rsp_dly[0] = 0;

    // Region boundaries and overlap priority.
    txn(64'h7_ffff_ffff, 1'b0, 64'd0);
    txn(64'hf_ffff_ffff, 1'b0, 64'd0);
    txn(64'h8_0000_0000, 1'b0, 64'd0);
    txn(64'h0, 1'b1, 64'h55);
    set_bounds(64'h0, 64'h9_0000_0000, DM_BOTTOM_DEF, DM_TOP_DEF);
    txn(64'h8_8000_0000, 1'b0, 64'd0);
    txn(64'h9_0000_0001, 1'b0, 64'd0);

    // Randomized traffic with stray responses and run-enable gaps.
    noise_en = 1'b1;
    for (int it = 0; it < 120; it++) begin
      logic [63:0] b;
      logic [63:0] a;
      if (it % 20 == 0) begin
        case ($urandom_range(0, 2))
          0: set_bounds(IM_BOTTOM_DEF, IM_TOP_DEF, DM_BOTTOM_DEF, DM_TOP_DEF);
          1: set_bounds(64'h1000, 64'h9_0000_0000, 64'h8_0000_0000, 64'hf_ffff_ffff);
          default: begin
            b = 64'($urandom_range(0, 32'h0fff_ffff));
            set_bounds(b, b + 64'($urandom_range(0, 32'h00ff_ffff)),
                       b + 64'h0100_0000, b + 64'h0100_0000 + 64'($urandom_range(0, 32'h0fff_ffff)));
          end
        endcase
      end
      for (int m = 0; m < 2; m++) begin
        rdy_dly[m] = $urandom_range(0, 3);
        rsp_dly[m] = $urandom_range(0, 3);
      end
      case ($urandom_range(0, 4))
        0: b = {$urandom, $urandom};
        1: b = im_bottom;
        2: b = im_top;
        3: b = dm_bottom;
        default: b = dm_top;
      endcase
      a = b + 64'($urandom_range(0, 4)) - 64'd2;
      if ($urandom_range(0, 7) == 0) begin
        continue_val = 1'b0;
        req_valid = 1'b1; req_addr = a;
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
          #1;
          chk("rand_blocked_req_ready", {63'd0, req_ready}, 64'd0);
          @(negedge clk);
        end
        req_valid = 1'b0;
        continue_val = 1'b1;
      end
      txn(a, 1'($urandom_range(0, 1)), {$urandom, $urandom});
    end
    noise_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
